// File: rtl/sample_framer.sv
// Sample framer: buffers accepted samples in a FIFO, tags frame boundaries
// and presents them through a registered valid/ready output stage.
module sample_framer #(
  parameter int SIZE_DATA  = 16,
  parameter int FRAME_LEN  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE_DATA-1:0]   input_data,
  input  logic                          input_valid,
  output logic signed [SIZE_DATA-1:0]   out_data,
  output logic                          out_first,
  output logic                          out_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(FRAME_LEN);
  localparam int EW = SIZE_DATA + 2;

  // Stream handshake: a sample transfers on a rising edge where out_valid and
  // out_ready are both high; out_valid is purely registered.

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [IW-1:0] idx;
  logic          full, empty;
  logic          push, pop;
  logic [LW-1:0] level_next;
  logic          tag_first, tag_last;
  logic [EW-1:0] head;

  // full is the registered flag, so a write into a full FIFO is dropped even
  // when the output stage pops in the same cycle.
  assign push      = input_valid && !full;
  assign pop       = !empty && (!out_valid || out_ready);
  assign tag_first = (idx == '0);
  assign tag_last  = (idx == IW'(FRAME_LEN - 1));
  assign head      = mem[rd_ptr];

  always_comb begin
    level_next = fifo_level;
    if (push && !pop)
      level_next = fifo_level + LW'(1);
    else if (!push && pop)
      level_next = fifo_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {tag_first, tag_last, input_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      idx            <= '0;
      fifo_level     <= '0;
      full           <= 1'b0;
      empty          <= 1'b1;
      overflow_count <= '0;
    end else begin
      fifo_level <= level_next;
      full       <= (level_next == LW'(FIFO_DEPTH));
      empty      <= (level_next == '0);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        idx    <= tag_last ? '0 : idx + IW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (input_valid && full && overflow_count != 16'hFFFF)
        overflow_count <= overflow_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_first <= head[EW-1];
      out_last  <= head[EW-2];
      out_data  <= head[SIZE_DATA-1:0];
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sample_framer.sv
// Scoreboard bench for sample_framer: directed writes push expected
// {first,last,data} words; a monitor pops and compares on every transfer.
module tb_sample_framer;

  localparam int SIZE_DATA  = 16;
  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int W          = SIZE_DATA + 2;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic signed [SIZE_DATA-1:0]  input_data = '0;
  logic                         input_valid = 1'b0;
  logic signed [SIZE_DATA-1:0]  out_data;
  logic                         out_first, out_last, out_valid;
  logic                         out_ready = 1'b0;
  logic [$clog2(FIFO_DEPTH):0]  fifo_level;
  logic [15:0]                  overflow_count;

  logic [W-1:0] exp_q[$];
  int           exp_idx = 0;
  int           checks = 0;
  int           failures = 0;

  sample_framer #(
    .SIZE_DATA(SIZE_DATA), .FRAME_LEN(FRAME_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .input_valid(input_valid),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level),
    .overflow_count(overflow_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic write_sample(input logic [SIZE_DATA-1:0] v, input bit accepted);
    input_data  = v;
    input_valid = 1'b1;
    if (accepted) begin
      exp_q.push_back({exp_idx == 0, exp_idx == FRAME_LEN - 1, v});
      exp_idx = (exp_idx == FRAME_LEN - 1) ? 0 : exp_idx + 1;
    end
    cycle();
    input_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= 300) begin
      failures++;
      $display("FAIL %s: drain timeout, %0d samples outstanding expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_data"},  32'(out_data), 32'h0);
    check({name, "_first"}, 32'(out_first), 32'h0);
    check({name, "_last"},  32'(out_last), 32'h0);
    check({name, "_valid"}, 32'(out_valid), 32'h0);
    check({name, "_level"}, 32'(fifo_level), 32'h0);
    check({name, "_ovf"},   32'(overflow_count), 32'h0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream: unexpected output %0h expected none", {out_first, out_last, out_data});
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_first, out_last, out_data} !== e) begin
          failures++;
          $display("FAIL stream: got first=%0b last=%0b data=%0d expected first=%0b last=%0b data=%0d",
                   out_first, out_last, out_data, e[W-1], e[W-2], e[SIZE_DATA-1:0]);
        end
      end
    end
  end

  initial begin
    // reset
    repeat (3) cycle();
    check_all_zero("reset");
    reset = 1'b1;
    cycle();

    // basic framing, including first-sample latency
    out_ready = 1'b1;
    write_sample(16'd1, 1'b1);
    check("lat_valid0", 32'(out_valid), 32'h0);
    check("lat_level1", 32'(fifo_level), 32'h1);
    write_sample(16'd2, 1'b1);
    check("lat_valid1", 32'(out_valid), 32'h1);
    check("lat_data1", 32'(out_data), 32'h1);
    for (int v = 3; v <= 20; v++) write_sample(16'(v), 1'b1);
    wait_drain("basic");
    check("basic_ovf", 32'(overflow_count), 32'h0);

    // back-pressure hold
    out_ready = 1'b0;
    write_sample(16'd5, 1'b1);
    cycle();
    check("bp_data_a", 32'(out_data), 32'd5);
    check("bp_level0", 32'(fifo_level), 32'd0);
    for (int v = 6; v <= 8; v++) begin
      write_sample(16'(v), 1'b1);
      check("bp_hold", 32'(out_data), 32'd5);
      check("bp_level", 32'(fifo_level), 32'(v - 5));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_b2b_valid", 32'(out_valid), 32'h1);
      cycle();
    end
    check("bp_idle", 32'(out_valid), 32'h0);
    wait_drain("bp");

    // overflow: 18..20 dropped
    out_ready = 1'b0;
    for (int v = 1; v <= 20; v++) write_sample(16'(v), v <= 17);
    check("ovf_out", 32'(out_data), 32'd1);
    check("ovf_level", 32'(fifo_level), 32'd16);
    check("ovf_count", 32'(overflow_count), 32'd3);
    wait_drain("ovf");
    write_sample(16'd100, 1'b1);
    wait_drain("ovf_100");
    check("ovf_count_kept", 32'(overflow_count), 32'd3);

    // full with simultaneous pop
    out_ready = 1'b0;
    for (int v = 200; v <= 216; v++) write_sample(16'(v), 1'b1);
    check("fp_level16", 32'(fifo_level), 32'd16);
    out_ready = 1'b1;
    write_sample(16'd999, 1'b0);
    out_ready = 1'b0;
    check("fp_count", 32'(overflow_count), 32'd4);
    check("fp_level15", 32'(fifo_level), 32'd15);
    wait_drain("fp");

    // reset mid-frame
    out_ready = 1'b0;
    for (int v = 1; v <= 5; v++) write_sample(16'(v), 1'b1);
    reset = 1'b0;
    exp_q.delete();
    exp_idx = 0;
    #1;
    check_all_zero("midrst");
    cycle();
    reset = 1'b1;
    out_ready = 1'b1;
    write_sample(16'd42, 1'b1);
    wait_drain("midrst");

    // saturation of the drop counter
    out_ready = 1'b0;
    for (int v = 300; v <= 316; v++) write_sample(16'(v), 1'b1);
    input_data  = 16'hBEEF;
    input_valid = 1'b1;
    repeat (65540) cycle();
    input_valid = 1'b0;
    check("sat_count", 32'(overflow_count), 32'hFFFF);
    wait_drain("sat");
    write_sample(16'hFFFF, 1'b1);
    write_sample(16'h8000, 1'b1);
    write_sample(16'd7, 1'b1);
    wait_drain("sat_resume");
    check("sat_count_kept", 32'(overflow_count), 32'hFFFF);
    check("sat_level", 32'(fifo_level), 32'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
